// File: rtl/conv_mac_array.sv
// conv_mac_array: CHANNELS parallel signed MAC lanes. Each lane accumulates KLEN
// pixel*weight taps on top of a bias loaded with tap 0. It then produces one
// result per lane through optional ReLU, an arithmetic right shift and a clamp
// to DATA_W, and holds that result under a valid/ready handshake.
module conv_mac_array #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 4,
  parameter int KLEN     = 9,
  parameter int ACC_W    = 24,
  parameter int SHIFT    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   pixel,
  input  logic [CHANNELS*DATA_W-1:0]   weight,
  input  logic [CHANNELS*DATA_W-1:0]   bias,
  input  logic                         relu_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         busy
);

  localparam int CNT_W = $clog2(KLEN + 1);
  localparam logic signed [ACC_W-1:0] MAX_A = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MIN_A = -MAX_A - ACC_W'(1);

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic                       relu_q;
  logic signed [ACC_W-1:0]    acc     [CHANNELS];
  logic signed [ACC_W-1:0]    acc_nxt [CHANNELS];
  logic [CHANNELS*DATA_W-1:0] res_data;
  logic                       relu_eff;
  logic                       take_tap;

  // ReLU, floor shift, then clamp the accumulator into the DATA_W result range
  function automatic logic signed [DATA_W-1:0] sat_shift(
    input logic signed [ACC_W-1:0] a,
    input logic                    relu
  );
    logic signed [ACC_W-1:0] r;
    r = (relu && (a < 0)) ? '0 : a;
    r = r >>> SHIFT;
    if (r > MAX_A)
      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (r < MIN_A)
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return r[DATA_W-1:0];
  endfunction

  assign in_ready = en && !rst && (state != OUTPUT);
  assign take_tap = in_valid && in_ready;
  assign busy     = (state != IDLE);
  // relu_en only matters on tap 0; afterwards the latched copy rules
  assign relu_eff = (state == IDLE) ? relu_en : relu_q;

  // Per-lane next accumulator (bias load on tap 0, add otherwise) and its saturated result
  always_comb begin
    res_data = '0;
    for (int l = 0; l < CHANNELS; l++) begin
      logic signed [DATA_W-1:0]   px;
      logic signed [DATA_W-1:0]   wt;
      logic signed [2*DATA_W-1:0] prod;
      logic signed [ACC_W-1:0]    prod_ext;
      logic signed [ACC_W-1:0]    bias_ext;
      px       = pixel[l*DATA_W +: DATA_W];
      wt       = weight[l*DATA_W +: DATA_W];
      prod     = px * wt;
      prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      bias_ext = {{(ACC_W-DATA_W){bias[l*DATA_W+DATA_W-1]}}, bias[l*DATA_W +: DATA_W]};
      if (state == IDLE)
        acc_nxt[l] = bias_ext + prod_ext;
      else
        acc_nxt[l] = acc[l] + prod_ext;
      res_data[l*DATA_W +: DATA_W] = sat_shift(acc_nxt[l], relu_eff);
    end
  end

  // Control FSM plus accumulator and output registers; en=0 freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      relu_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int l = 0; l < CHANNELS; l++) acc[l] <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (take_tap) begin
            acc    <= acc_nxt;
            relu_q <= relu_en;
            cnt    <= CNT_W'(1);
            if (KLEN == 1) begin
              state     <= OUTPUT;
              out_valid <= 1'b1;
              out_data  <= res_data;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (take_tap) begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            // final tap: result registered in the same edge, valid next cycle
            if (cnt == CNT_W'(KLEN - 1)) begin
              state     <= OUTPUT;
              out_valid <= 1'b1;
              out_data  <= res_data;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cnt       <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_array.sv
// Bench for conv_mac_array: directed tap sequences, a transaction-level model of
// the sum/ReLU/shift/clamp rules, and literal expectations for key vectors.
module tb_conv_mac_array;

  localparam int DW   = 8;
  localparam int CH   = 4;
  localparam int KL   = 9;
  localparam int AW   = 24;
  localparam int SH   = 4;

  logic              clk = 1'b0;
  logic              rst, en, in_valid, in_ready, relu_en;
  logic              out_valid, out_ready, busy;
  logic [CH*DW-1:0]  pixel, weight, bias, out_data;

  int errors = 0;
  int checks = 0;
  bit running = 0;

  // model state: taps gathered so far, whether a result is pending, per-lane sums
  int     m_taps = 0;
  bit     m_have = 0;
  bit     m_relu = 0;
  longint m_sum [CH];
  longint m_exp [CH];

  conv_mac_array #(.DATA_W(DW), .CHANNELS(CH), .KLEN(KL), .ACC_W(AW), .SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .pixel(pixel), .weight(weight), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint lane(input logic [CH*DW-1:0] v, input int l);
    logic signed [DW-1:0] s;
    s = v[l*DW +: DW];
    return longint'(s);
  endfunction

  function automatic longint ref_res(input longint s, input bit relu);
    longint r;
    r = (relu && s < 0) ? 0 : s;
    r = r >>> SH;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  // model: applies the accept/consume rules on each rising edge
  always @(posedge clk) begin
    if (rst) begin
      m_taps = 0; m_have = 0; m_relu = 0;
    end else if (en) begin
      if (m_have) begin
        if (out_ready) m_have = 0;
      end else if (in_valid) begin
        for (int l = 0; l < CH; l++) begin
          if (m_taps == 0) m_sum[l] = lane(bias, l) + lane(pixel, l) * lane(weight, l);
          else             m_sum[l] = m_sum[l] + lane(pixel, l) * lane(weight, l);
        end
        if (m_taps == 0) m_relu = relu_en;
        m_taps++;
        if (m_taps == KL) begin
          for (int l = 0; l < CH; l++) m_exp[l] = ref_res(m_sum[l], m_relu);
          m_have = 1;
          m_taps = 0;
        end
      end
    end
  end

  // compare: every falling edge once out of initial reset
  always @(negedge clk) begin
    if (running) begin
      chk("in_ready", in_ready, (en && !rst && !m_have) ? 1 : 0);
      chk("out_valid", out_valid, m_have);
      chk("busy", busy, (m_have || m_taps > 0) ? 1 : 0);
      if (m_have)
        for (int l = 0; l < CH; l++) chk($sformatf("out_data[%0d]", l), lane(out_data, l), m_exp[l]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int p, input int w, input int b);
    for (int l = 0; l < CH; l++) begin
      pixel[l*DW +: DW]  = p[DW-1:0];
      weight[l*DW +: DW] = w[DW-1:0];
      bias[l*DW +: DW]   = b[DW-1:0];
    end
  endtask

  task automatic run_taps(input int n);
    in_valid = 1;
    repeat (n) step();
    in_valid = 0;
  endtask

  task automatic expect_lanes(input string name, input int e0, input int e1, input int e2, input int e3);
    int budget;
    budget = 0;
    while (!out_valid && budget < 50) begin step(); budget++; end
    chk({name, "_valid_seen"}, out_valid, 1);
    chk({name, "_l0"}, lane(out_data, 0), e0);
    chk({name, "_l1"}, lane(out_data, 1), e1);
    chk({name, "_l2"}, lane(out_data, 2), e2);
    chk({name, "_l3"}, lane(out_data, 3), e3);
  endtask

  task automatic take(input string name);
    in_valid  = 0;
    out_ready = 1;
    step();
    out_ready = 0;
    chk({name, "_cleared"}, out_valid, 0);
    chk({name, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [CH*DW-1:0] held;
    rst = 1; en = 1; in_valid = 0; out_ready = 0; relu_en = 0;
    pixel = '0; weight = '0; bias = '0;
    step(); step();
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);
    running = 1;

    // basic: 2*3*9 = 54, >>>4 = 3
    set_all(2, 3, 0); relu_en = 0;
    run_taps(KL);
    chk("basic_latency", out_valid, 1);
    expect_lanes("basic", 3, 3, 3, 3);
    take("basic");

    // negative: -54 >>> 4 = -4 ; with ReLU -> 0
    set_all(-2, 3, 0); relu_en = 0;
    run_taps(KL);
    expect_lanes("neg", -4, -4, -4, -4);
    take("neg");
    relu_en = 1;
    run_taps(KL);
    expect_lanes("neg_relu", 0, 0, 0, 0);
    take("neg_relu");

    // saturation: +clamp, -clamp, bias-only -128>>>4 = -8
    set_all(127, 127, 0); relu_en = 0;
    pixel[1*DW +: DW] = 8'h80;
    pixel[2*DW +: DW] = 8'h00; bias[2*DW +: DW] = 8'h80;
    run_taps(KL);
    expect_lanes("sat", 127, -128, -8, 127);
    take("sat");

    // backpressure with in_valid held high: nothing accepted, output frozen
    set_all(2, 3, 0);
    run_taps(KL);
    held = out_data;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_hold", out_data, held);
      chk("bp_in_ready", in_ready, 0);
    end
    take("bp");

    // reset discards a partial accumulation
    set_all(5, 7, 3);
    run_taps(4);
    rst = 1; in_valid = 1;
    #1;
    chk("rst_mid_in_ready", in_ready, 0);
    step();
    rst = 0; in_valid = 0;
    #1;
    chk("rst_mid_busy", busy, 0);
    set_all(2, 3, 0);
    run_taps(KL);
    expect_lanes("after_rst", 3, 3, 3, 3);
    take("after_rst");

    // en=0 for 3 cycles mid-accumulation: taps not counted
    run_taps(4);
    en = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_low_in_ready", in_ready, 0);
      chk("en_low_busy", busy, 1);
    end
    en = 1;
    run_taps(5);
    chk("en_latency", out_valid, 1);
    expect_lanes("en_gap", 3, 3, 3, 3);
    take("en_gap");

    // per-lane values, gaps between taps, bias changed after tap 0, ReLU on
    pixel  = {8'sd104 ^ 8'h00 ? 8'(-40) : 8'(-40), 8'(30), 8'(-20), 8'(10)};
    weight = {8'(-13), 8'(11), 8'(9), 8'(-7)};
    bias   = {8'(-80), 8'(70), 8'(-60), 8'(50)};
    relu_en = 1;
    for (int t = 0; t < KL; t++) begin
      in_valid = 1;
      step();
      in_valid = 0;
      bias = '0; relu_en = 0;
      if (t % 2 == 0) step();
    end
    // -580->0, -1680->0, 3040>>>4=190->127, 4600>>>4=287->127
    expect_lanes("mixed", 0, 0, 127, 127);
    take("mixed");

    step();
    running = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_mac_array.md
CONV_MAC_ARRAY -- requirements
Module: conv_mac_array

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed width of pixel, weight, bias and result lanes.
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent parallel MAC lanes.
REQ-003 SHALL have parameter KLEN, default 9, taps accumulated per output (3x3 kernel).
REQ-004 SHALL have parameter ACC_W, default 24, accumulator width; legal only if ACC_W >= 2*DATA_W + clog2(KLEN) + 1.
REQ-005 SHALL have parameter SHIFT, default 4, arithmetic right shift applied before output saturation.
REQ-006 SHALL have port clk  input  1  sole clock, all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port en  input  1  global enable; low freezes all state.
REQ-009 SHALL have port in_valid  input  1  tap data valid.
REQ-010 SHALL have port in_ready  output  1  block accepts a tap this cycle.
REQ-011 SHALL have port pixel  input  CHANNELS*DATA_W  per-lane signed pixel, lane 0 in LSBs.
REQ-012 SHALL have port weight  input  CHANNELS*DATA_W  per-lane signed weight.
REQ-013 SHALL have port bias  input  CHANNELS*DATA_W  per-lane signed bias, sampled with tap 0 only.
REQ-014 SHALL have port relu_en  input  1  ReLU mode, sampled with tap 0 only.
REQ-015 SHALL have port out_valid  output  1  result valid.
REQ-016 SHALL have port out_ready  input  1  consumer accepts result.
REQ-017 SHALL have port out_data  output  CHANNELS*DATA_W  per-lane signed saturated result.
REQ-018 SHALL have port busy  output  1  high in ACCUM or OUTPUT.

Function
REQ-019 SHALL implement FSM states IDLE, ACCUM, OUTPUT.
REQ-020 in_ready SHALL be high exactly when en=1 and state is IDLE or ACCUM; a tap is accepted on in_valid&&in_ready.
REQ-021 Tap accepted in IDLE SHALL load acc[lane] = sext(bias[lane]) + pixel[lane]*weight[lane], latch relu_en, set tap count to 1, go to ACCUM (KLEN=1: go directly to OUTPUT).
REQ-022 Tap accepted in ACCUM SHALL add the signed full-precision product into acc[lane] and increment tap count.
REQ-023 Acceptance of tap KLEN-1 (0-based) SHALL move to OUTPUT; out_valid SHALL be high the following cycle (latency 1 from final tap).
REQ-024 Result per lane SHALL be: r = acc; if latched relu and r<0 then r=0; r = r >>> SHIFT (arithmetic, floor); clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-025 out_data SHALL be registered and stable while out_valid=1 and out_ready=0.
REQ-026 In OUTPUT, out_valid&&out_ready&&en SHALL return FSM to IDLE and clear out_valid the next cycle; no tap is accepted in that cycle.
REQ-027 en=0 SHALL hold state, tap count, accumulators, out_valid and out_data; in_ready=0.
REQ-028 Cycles with in_valid=0 in ACCUM SHALL leave accumulators unchanged (gaps allowed).
REQ-029 Accumulation SHALL never overflow given REQ-004; no wrap-around handling is required.

Reset
REQ-030 rst=1 on a clock edge SHALL force IDLE, tap count 0, accumulators 0, out_valid 0, out_data 0, latched relu 0, regardless of en or state.
REQ-031 rst SHALL take priority over every handshake in the same cycle; a partial accumulation is discarded.
REQ-032 During rst=1 in_ready SHALL be 0; busy SHALL be 0 from the cycle after reset.

Verification
REQ-033 Defaults, all lanes pixel=2 weight=3 bias=0 relu=0, 9 back-to-back taps -> out_valid 1 cycle after tap 9, every lane =3 (54>>>4).
REQ-034 pixel=-2 weight=3 bias=0: relu=0 -> every lane -4 (-54>>>4); relu=1 -> every lane 0.
REQ-035 Saturation: pixel=127 weight=127 -> lane 127; lane 1 pixel=-128 weight=127 -> -128; lane 2 bias=-128, pixel=0 -> -8.
REQ-036 Backpressure: out_ready=0 for 5 cycles -> out_valid held, out_data unchanged, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-037 rst pulse after 4 taps, then 9 fresh taps of REQ-033 -> result 3 per lane (no residue); en=0 for 3 cycles mid-accumulation with in_valid=1 -> no taps counted, final result unchanged.
